// File: rtl/img_sram_pkg.sv
// Shared image-SRAM types: control bundle, dimension width and unloader FSM states.
package img_sram_pkg;

    localparam int unsigned IMG_DIM_W = 8;
    localparam int unsigned IMG_PIX_W = 8;

    typedef struct packed {
        logic [IMG_DIM_W-1:0] row;
        logic [IMG_DIM_W-1:0] col;
        logic                 write_en;
        logic                 sense_en;
        logic [IMG_PIX_W-1:0] din;
    } img_sram_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } unload_state_e;

endpackage

// File: rtl/img_stream_unloader_fifo.sv
// Small synchronous FIFO; simultaneous push and pop are legal when full or empty.
module pix_skid_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO only lands if the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/img_stream_unloader.sv
// Streams a finished image out of the image SRAM, row- or column-major, over a
// valid/ready byte stream with credit-based prefetch hiding the SRAM read latency.
module img_stream_unloader
    import img_sram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PIX_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IMG_DIM_W-1:0] nrows,
    input  logic [IMG_DIM_W-1:0] ncols,
    input  logic                 transpose_out,
    output logic                 busy,
    output logic                 done,
    input  logic [PIX_W-1:0]     sram_dout_in,
    output img_sram_ctrl_t       sram_ctrl,
    output logic [PIX_W-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_eol,
    output logic                 m_last
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    unload_state_e        state_q, state_d;
    logic [IMG_DIM_W-1:0] outer_max_q, outer_max_d;
    logic [IMG_DIM_W-1:0] inner_max_q, inner_max_d;
    logic                 tr_q, tr_d;
    logic [IMG_DIM_W-1:0] o_q, o_d;
    logic [IMG_DIM_W-1:0] i_q, i_d;
    logic [IMG_DIM_W-1:0] row_q, row_d;
    logic [IMG_DIM_W-1:0] col_q, col_d;
    logic                 pipe_v_q, pipe_eol_q, pipe_last_q;

    logic [PIX_W+1:0]     fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full, fifo_empty;
    logic                 pop, issue, can_issue;
    logic                 inner_end, outer_end, final_addr;
    logic [CW:0]          credit;
    logic [IMG_DIM_W-1:0] cur_row, cur_col;

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_dout[PIX_W-1:0];
    assign m_eol   = fifo_dout[PIX_W];
    assign m_last  = fifo_dout[PIX_W+1];
    assign pop     = m_valid && m_ready;

    // Entries held + read in flight - entry leaving this edge must stay below depth.
    assign credit     = (CW+1)'(fifo_count) + (CW+1)'(pipe_v_q) - (CW+1)'(pop);
    assign can_issue  = (credit < (CW+1)'(FIFO_DEPTH));
    assign inner_end  = (i_q == inner_max_q);
    assign outer_end  = (o_q == outer_max_q);
    assign final_addr = inner_end && outer_end;
    assign cur_row    = tr_q ? i_q : o_q;
    assign cur_col    = tr_q ? o_q : i_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (nrows == '0 || ncols == '0) ? DONE : ISSUE;
            ISSUE:   if (issue && final_addr) state_d = DRAIN;
            DRAIN:   if (pop && m_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ISSUE) || (state_q == DRAIN);
        done  = (state_q == DONE);
        issue = (state_q == ISSUE) && can_issue;
    end

    always_comb begin
        outer_max_d = outer_max_q;
        inner_max_d = inner_max_q;
        tr_d        = tr_q;
        o_d         = o_q;
        i_d         = i_q;
        row_d       = row_q;
        col_d       = col_q;
        if (state_q == IDLE && start) begin
            tr_d        = transpose_out;
            outer_max_d = (transpose_out ? ncols : nrows) - IMG_DIM_W'(1);
            inner_max_d = (transpose_out ? nrows : ncols) - IMG_DIM_W'(1);
            o_d         = '0;
            i_d         = '0;
        end
        if (issue) begin
            row_d = cur_row;
            col_d = cur_col;
            if (inner_end) begin
                i_d = '0;
                o_d = o_q + IMG_DIM_W'(1);
            end else begin
                i_d = i_q + IMG_DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outer_max_q <= '0;
            inner_max_q <= '0;
            tr_q        <= 1'b0;
            o_q         <= '0;
            i_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pipe_v_q    <= 1'b0;
            pipe_eol_q  <= 1'b0;
            pipe_last_q <= 1'b0;
        end else begin
            outer_max_q <= outer_max_d;
            inner_max_q <= inner_max_d;
            tr_q        <= tr_d;
            o_q         <= o_d;
            i_q         <= i_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pipe_v_q    <= issue;
            pipe_eol_q  <= issue && inner_end;
            pipe_last_q <= issue && final_addr;
        end
    end

    // Address is live in the issue cycle and held afterwards.
    always_comb begin
        sram_ctrl          = '0;
        sram_ctrl.row      = issue ? cur_row : row_q;
        sram_ctrl.col      = issue ? cur_col : col_q;
        sram_ctrl.write_en = 1'b0;
        sram_ctrl.sense_en = 1'b0;
        sram_ctrl.din      = '0;
    end

    pix_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pipe_v_q),
        .din_i   ({pipe_last_q, pipe_eol_q, sram_dout_in}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_img_stream_unloader.sv
// Scoreboard bench for img_stream_unloader: stimulus pushes expected beats, a
// negedge monitor pops and compares each transferred beat.
module tb_img_stream_unloader;
    import img_sram_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       eol;
        logic       last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     nrows = '0;
    logic [7:0]     ncols = '0;
    logic           transpose_out = 1'b0;
    logic           busy, done;
    logic [7:0]     sram_dout_in = '0;
    img_sram_ctrl_t sram_ctrl;
    logic [7:0]     m_data;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic           m_eol, m_last;

    int    compared = 0;
    int    mismatched = 0;
    int    cyc = 0;
    int    run_beats = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    start_cyc = 0;
    bit    rnd_mode = 1'b0;
    bit    hold_pend = 1'b0;
    beat_t held;
    beat_t sb[$];

    img_stream_unloader #(
        .FIFO_DEPTH (2),
        .PIX_W      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .nrows         (nrows),
        .ncols         (ncols),
        .transpose_out (transpose_out),
        .busy          (busy),
        .done          (done),
        .sram_dout_in  (sram_dout_in),
        .sram_ctrl     (sram_ctrl),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_eol         (m_eol),
        .m_last        (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM model holding pixel = row*16 + col.
    always @(posedge clk) sram_dout_in <= 8'(sram_ctrl.row * 16 + sram_ctrl.col);

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst && dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.pop_i) begin
            mismatched++;
            $display("FAIL fifo_overflow: write while full at cycle %0d (required none)", cyc);
        end
    end

    always @(negedge clk) begin
        beat_t got, exp;
        got = '{d: m_data, eol: m_eol, last: m_last};
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                compared++;
                if (!m_valid || got != held) begin
                    mismatched++;
                    $display("FAIL hold_stable: valid=%0b beat=%h required valid=1 beat=%h", m_valid, got, held);
                end
            end
            if (m_valid && m_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL beat_extra: got %h, required no beat", got);
                end else begin
                    exp = sb.pop_front();
                    if (got != exp) begin
                        mismatched++;
                        $display("FAIL beat_data: got d=%h eol=%0b last=%0b required d=%h eol=%0b last=%0b",
                                 got.d, got.eol, got.last, exp.d, exp.eol, exp.last);
                    end
                end
                run_beats++;
                if (run_beats == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            hold_pend = m_valid && !m_ready;
            held = got;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_expected(input int nr, input int nc, input bit tr);
        int outer, inner, r, c;
        bit eol, last;
        outer = tr ? nc : nr;
        inner = tr ? nr : nc;
        for (int o = 0; o < outer; o++) begin
            for (int i = 0; i < inner; i++) begin
                r = tr ? i : o;
                c = tr ? o : i;
                eol = (i == inner - 1);
                last = eol && (o == outer - 1);
                sb.push_back('{d: 8'(r * 16 + c), eol: eol, last: last});
            end
        end
    endtask

    task automatic pulse_start(input int nr, input int nc, input bit tr);
        @(posedge clk);
        #1;
        nrows = 8'(nr);
        ncols = 8'(nc);
        transpose_out = tr;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run(input string name, input int nr, input int nc, input bit tr,
                       input bit chk_timing, input bit mid_start);
        int n, dbase, bound;
        n = nr * nc;
        bound = n * 8 + 50;
        push_expected(nr, nc, tr);
        run_beats = 0;
        dbase = done_cnt;
        pulse_start(nr, nc, tr);
        for (int t = 0; t < bound; t++) begin
            if (done_cnt != dbase) break;
            @(posedge clk);
            #1;
            if (mid_start && t == 6) begin
                start = 1'b1;
                nrows = 8'd9;
                ncols = 8'd2;
                transpose_out = ~tr;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, "_done_seen"}, done_cnt - dbase, 1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, done_cnt - dbase, 1);
        check({name, "_beats"}, run_beats, n);
        check({name, "_sb_left"}, sb.size(), 0);
        check({name, "_busy_after"}, int'(busy), 0);
        if (chk_timing) begin
            if (n > 0) begin
                check({name, "_first_cyc"}, first_cyc - start_cyc, 2);
                check({name, "_last_cyc"}, last_cyc - start_cyc, n + 1);
                check({name, "_done_cyc"}, done_cyc - last_cyc, 1);
            end else begin
                check({name, "_done_cyc"}, done_cyc - start_cyc, 0);
            end
        end
        sb.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(m_valid), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_eol_last", int'({m_eol, m_last}), 0);
        check("rst_row_col", int'({sram_ctrl.row, sram_ctrl.col}), 0);
        check("rst_ctrl_rd_only", int'({sram_ctrl.write_en, sram_ctrl.sense_en, sram_ctrl.din}), 0);

        run("rowmaj_3x4", 3, 4, 1'b0, 1'b1, 1'b0);
        run("colmaj_3x4", 3, 4, 1'b1, 1'b1, 1'b0);

        rnd_mode = 1'b1;
        run("bp_3x4", 3, 4, 1'b0, 1'b0, 1'b0);
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;

        run("zero_rows", 0, 5, 1'b0, 1'b1, 1'b0);
        check("zero_rows_addr", int'({sram_ctrl.row, sram_ctrl.col}), int'({8'd2, 8'd3}));
        run("zero_cols", 4, 0, 1'b0, 1'b1, 1'b0);
        check("zero_cols_addr", int'({sram_ctrl.row, sram_ctrl.col}), int'({8'd2, 8'd3}));

        // Reset after the 5th beat of a 4x4 image, then a clean restart.
        push_expected(4, 4, 1'b0);
        run_beats = 0;
        pulse_start(4, 4, 1'b0);
        for (int t = 0; t < 200 && run_beats < 5; t++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_beats", run_beats, 5);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", int'(m_valid), 0);
        check("rst_mid_busy", int'(busy), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        run("restart_4x4", 4, 4, 1'b0, 1'b1, 1'b1);

        run("max_255", 255, 255, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/img_stream_unloader.md
Name: img_stream_unloader

Overview:
- Downstream stage of the row/column convolution passes: once a pass completes, streams the finished image out of an image SRAM over a valid/ready byte stream (to host or output DMA).
- Reads are row-major, or column-major when transpose_out is set. This undoes the transpose left by a transposing pass.
- Hides the 1-cycle SRAM read latency with a small credit-controlled FIFO. Sustains 1 pixel/cycle under continuous m_ready and never drops or duplicates a pixel under backpressure.

Parameters:
- FIFO_DEPTH, 2: output FIFO entries. Minimum 2, needed for full throughput.
- PIX_W, 8: pixel width. Must match the SRAM dout width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins an unload. Ignored while busy.
- nrows  in  8  image row count, sampled on an accepted start
- ncols  in  8  image column count, sampled on an accepted start
- transpose_out  in  1  1 = column-major read order. Sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  1-cycle pulse when the last beat is accepted or the image is empty
- sram_dout_in  in  PIX_W  SRAM read data, valid the cycle after the address
- sram_ctrl  out  img_sram_ctrl_t  SRAM control. This block only reads: write_en=0, sense_en=0, din=0.
- m_data  out  PIX_W  pixel
- m_valid  out  1  pixel valid
- m_ready  in  1  consumer ready
- m_eol  out  1  last pixel of the current output line (row, or column if transposed)
- m_last  out  1  last pixel of the image

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_data=0, m_eol=0, m_last=0, sram_ctrl row=0 col=0. FIFO empty, state IDLE, counters 0.
- Reset asserted mid-unload clears everything immediately, including m_valid. No handshake completes on that cycle.
- A beat transfers on a rising edge where m_valid && m_ready.
- Once m_valid is high, m_data, m_eol and m_last stay stable until the beat transfers.
- FSM states:
  - IDLE: waits for start. On start, latches nrows, ncols and transpose_out and clears the counters. Goes to DONE if nrows==0 or ncols==0, otherwise to ISSUE.
  - ISSUE: issues one read in a cycle when fifo_count + inflight - pop < FIFO_DEPTH. Here pop = (m_valid && m_ready) this cycle and inflight = a read issued last cycle. Moves to DRAIN after the final address is issued.
  - DRAIN: no reads. Goes to DONE on the edge where the final beat (m_last) transfers.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Address order:
  - Outer counter o runs 0..outer-1 and inner counter i runs 0..inner-1, 8-bit each. Inner wraps to 0 and increments outer.
  - transpose_out=0: row=o, col=i, outer=nrows, inner=ncols.
  - transpose_out=1: row=i, col=o, outer=ncols, inner=nrows.
- Each issued read carries eol=(i==inner-1) and last=(eol && o==outer-1) through a 1-cycle delay pipe. The delay pipe writes {data, eol, last} into the FIFO on the following edge.
- Latency: start sampled at edge k. The first address is driven in cycle k+1. Data is captured at edge k+2, so m_valid=1 from k+2.
- With m_ready held high, an N-pixel image produces N beats in N consecutive cycles. done is high in the cycle after the m_last beat transfers.
- The FIFO never overflows because of the credit rule, so the verifier asserts no write-when-full.
- FIFO push and pop in the same cycle are both legal, including when the FIFO is full or empty.
- While not issuing, sram_ctrl.row/col hold their last value. No read side effects occur.
- A start while busy or in DONE is ignored. Parameter changes mid-unload have no effect.
- 255x255 is the maximum image. Counter compares are done against latched dims minus one in 8 bits, so there is no overflow.

Decomposition:
- img_sram_pkg: reuse img_sram_ctrl_t.
- img_sram_pkg additions: IMG_DIM_W=8 and the unloader state enum (IDLE, ISSUE, DRAIN, DONE).
- Sub-module pix_skid_fifo (parameters DEPTH, W). Synchronous FIFO with push, pop, count, full and empty, async active-high reset. Payload = {last, eol, data}.

Test Plan:
- 3x4 image, pixel=row*16+col, m_ready=1, transpose_out=0: 12 beats on 12 consecutive cycles starting 2 cycles after start. Data sequence 00,01,02,03,10..23. m_eol on 03, 13, 23; m_last only on 23. done exactly 1 cycle after the 23 beat.
- Same image, transpose_out=1: beats 00,10,20,01,...,23. m_eol on every 3rd beat; m_last on 23.
- 3x4 image, random m_ready with 30% low: exactly 12 beats, in order, no drops or duplicates. m_data stable while m_valid && !m_ready. FIFO overflow assertion never fires.
- nrows=0 with ncols=5, and separately ncols=0: no SRAM reads, m_valid never high, done pulses 1 cycle after start.
- 255x255 image with m_ready=1: 65025 beats, final beat is row 254 col 254 with m_last. No counter wrap before then.
- Assert rst after the 5th beat of a 4x4 image, then restart: m_valid drops at once and the new unload begins cleanly from pixel 00. A start pulse sent mid-unload is ignored, and the beat count stays 16.
